// File: rtl/scroll_provider_pkg.sv
// Shared types and helpers for the scroll_provider row-data source.
// Optional horizontal scrolling is enabled by defining SCROLL_PROVIDER_SCROLL_EN.
package scroll_provider_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        LOAD,
        EMIT
    } state_t;

    localparam int GLYPH_W = 64;
    localparam logic [7:0] BLANK_CHAR = 8'h20;

    // Gather bit `row` of each of the eight glyph columns into one byte.
    function automatic logic [7:0] row_slice(
        input logic [GLYPH_W-1:0] glyph,
        input logic [2:0]         row
    );
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            b[k] = glyph[8*k + int'(row)];
        end
        return b;
    endfunction

endpackage

// File: rtl/scroll_byte_mux.sv
// Builds one row byte from two adjacent glyphs and a pixel shift.
// Bit j comes from glyph A column s+j, or glyph B column s+j-8 once past A.
module scroll_byte_mux
    import scroll_provider_pkg::*;
(
    input  logic [GLYPH_W-1:0] glyph_a,
    input  logic [GLYPH_W-1:0] glyph_b,
    input  logic [2:0]         shift,
    input  logic [2:0]         row,
    output logic [7:0]         col
);

    logic [15:0] pair;

    // Concatenate both row slices and shift the 8-column window into place.
    always_comb begin
        pair = {row_slice(glyph_b, row), row_slice(glyph_a, row)} >> shift;
        col  = pair[7:0];
    end

endmodule

// File: rtl/scroll_provider.sv
// Row-data source for cascaded MAX7219 matrices: message RAM, font fetch, byte emit.
// Define SCROLL_PROVIDER_SCROLL_EN to enable the pixel scroll offset.
module scroll_provider
    import scroll_provider_pkg::*;
#(
    parameter int MSG_LEN = 16,
    parameter int NUM_DEV = 4,
    parameter int FONT_AW = 7,
    localparam int MSG_W  = $clog2(MSG_LEN),
    localparam int DEV_W  = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               msg_we,
    input  logic [MSG_W-1:0]   msg_waddr,
    input  logic [7:0]         msg_wdata,
    input  logic               scroll_step,
    input  logic               start,
    output logic [FONT_AW-1:0] font_addr,
    input  logic [GLYPH_W-1:0] font_q,
    output logic               valid,
    input  logic               ready,
    output logic [7:0]         col,
    output logic [2:0]         row_idx,
    output logic [DEV_W-1:0]   dev_idx,
    output logic               busy,
    output logic               frame_done
);

    localparam int OFS_W = MSG_W + 3;

    state_t             state;
    logic [7:0]         msg [MSG_LEN];
    logic [OFS_W-1:0]   offset;
    logic [OFS_W-1:0]   frame_ofs;
    logic [GLYPH_W-1:0] glyph_a;

    logic [OFS_W-1:0]   g0_start;
    logic [OFS_W-1:0]   g0_cur;
    logic [OFS_W-1:0]   g0_nxt;
    logic [MSG_W-1:0]   slot_b;
    logic [2:0]         nxt_row;
    logic [DEV_W-1:0]   nxt_dev;
    logic               last_byte;
    logic [7:0]         mux_col;

    // First global pixel column shown on device `dev` for a given offset.
    function automatic logic [OFS_W-1:0] g0_of(
        input logic [OFS_W-1:0] ofs,
        input logic [DEV_W-1:0] dev
    );
        logic [OFS_W-1:0] d8;
        d8 = OFS_W'(dev) << 3;
        return ofs + d8;
    endfunction

    // Message RAM; slots start out as blanks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg[i] <= BLANK_CHAR;
            end
        end else if (msg_we) begin
            msg[msg_waddr] <= msg_wdata;
        end
    end

`ifdef SCROLL_PROVIDER_SCROLL_EN
    // Scroll offset advances one pixel per step and wraps at the message width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset <= '0;
        end else if (scroll_step) begin
            offset <= offset + 1'b1;
        end
    end
`else
    logic step_unused;
    assign offset      = '0;
    assign step_unused = scroll_step;
`endif

    // Byte addressing: current and next (row, device) and their glyph slots.
    always_comb begin
        last_byte = (row_idx == 3'd7) && (dev_idx == '0);
        if (dev_idx == '0) begin
            nxt_dev = DEV_W'(NUM_DEV - 1);
            nxt_row = row_idx + 3'd1;
        end else begin
            nxt_dev = dev_idx - 1'b1;
            nxt_row = row_idx;
        end
        g0_start = g0_of(offset, DEV_W'(NUM_DEV - 1));
        g0_cur   = g0_of(frame_ofs, dev_idx);
        g0_nxt   = g0_of(frame_ofs, nxt_dev);
        slot_b   = g0_cur[OFS_W-1:3] + 1'b1;
    end

    scroll_byte_mux u_mux (
        .glyph_a (glyph_a),
        .glyph_b (font_q),
        .shift   (g0_cur[2:0]),
        .row     (row_idx),
        .col     (mux_col)
    );

    // Frame sequencer: two glyph fetches, one load, then hold until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            col        <= '0;
            row_idx    <= '0;
            dev_idx    <= '0;
            font_addr  <= '0;
            frame_ofs  <= '0;
            glyph_a    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    if (start && !busy) begin
                        state     <= FETCH_A;
                        busy      <= 1'b1;
                        frame_ofs <= offset;
                        row_idx   <= '0;
                        dev_idx   <= DEV_W'(NUM_DEV - 1);
                        font_addr <= msg[g0_start[OFS_W-1:3]][FONT_AW-1:0];
                    end
                end
                FETCH_A: begin
                    font_addr <= msg[slot_b][FONT_AW-1:0];
                    state     <= FETCH_B;
                end
                FETCH_B: begin
                    glyph_a <= font_q;
                    state   <= LOAD;
                end
                LOAD: begin
                    col   <= mux_col;
                    valid <= 1'b1;
                    state <= EMIT;
                end
                EMIT: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (last_byte) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                        end else begin
                            row_idx   <= nxt_row;
                            dev_idx   <= nxt_dev;
                            font_addr <= msg[g0_nxt[OFS_W-1:3]][FONT_AW-1:0];
                            state     <= FETCH_A;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
